// File: rtl/imem_arbiter.sv
// Single-port program-memory arbiter: instruction fetch vs. loader/debug port.
// Grants and memory-port signals are combinational from the current requests
// and state. Read data is returned one cycle after a read grant, routed by a
// registered owner tag.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_clr,
  // Fetch side
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_gnt,
  output logic              o_fetch_stall,
  output logic              o_fetch_rvalid,
  output logic [31:0]       o_fetch_rdata,
  // Loader side
  input  logic              i_ld_lock,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [31:0]       i_ld_wdata,
  output logic              o_ld_gnt,
  output logic              o_ld_rvalid,
  output logic [31:0]       o_ld_rdata,
  output logic              o_ld_locked,
  output logic [15:0]       o_ld_wr_count,
  // Memory port
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic {StRun, StLoad} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic        r_tag_fetch;
  logic        r_tag_ld;
  logic [31:0] r_fetch_rdata;
  logic [31:0] r_ld_rdata;
  logic [15:0] r_wr_count;
  logic        w_fetch_gnt;
  logic        w_ld_gnt;
  logic        w_fetch_rvalid;
  logic        w_ld_rvalid;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: lock mode simply follows ld_lock, taking effect at the edge
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StRun:   if (i_ld_lock)  w_state_nxt = StLoad;
      StLoad:  if (!i_ld_lock) w_state_nxt = StRun;
      default: w_state_nxt = StRun;
    endcase
  end

  // Grant decode from current state; loader wins ties unless fetch is starved
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_ld_gnt    = 1'b0;
    if (!i_clr) begin
      unique case (r_state)
        StRun: begin
          if (i_fetch_req && i_ld_req) begin
            w_fetch_gnt = (r_starve_cnt == StarveMax);
            w_ld_gnt    = (r_starve_cnt != StarveMax);
          end else begin
            w_fetch_gnt = i_fetch_req;
            w_ld_gnt    = i_ld_req;
          end
        end
        StLoad:  w_ld_gnt = i_ld_req;
        default: ;
      endcase
    end
  end

  // Memory port mux; idle port drives zeros
  always_comb begin
    o_mem_en    = w_fetch_gnt | w_ld_gnt;
    o_mem_we    = w_ld_gnt & i_ld_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_fetch_gnt) begin
      o_mem_addr = i_fetch_addr;
    end else if (w_ld_gnt) begin
      o_mem_addr  = i_ld_addr;
      o_mem_wdata = i_ld_wdata;
    end
  end

  // Starvation counter next value: counts consecutive lost fetch cycles in RUN
  always_comb begin
    w_starve_nxt = '0;
    if (r_state == StRun && i_fetch_req && !w_fetch_gnt) begin
      w_starve_nxt = (r_starve_cnt == StarveMax) ? r_starve_cnt : r_starve_cnt + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Owner tag: which requester's read data arrives next cycle (writes return nothing)
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_tag_fetch <= 1'b0;
      r_tag_ld    <= 1'b0;
    end else begin
      r_tag_fetch <= w_fetch_gnt;
      r_tag_ld    <= w_ld_gnt & ~i_ld_we;
    end
  end

  // A return landing in a reset cycle is dropped
  assign w_fetch_rvalid = r_tag_fetch & ~i_clr;
  assign w_ld_rvalid    = r_tag_ld & ~i_clr;

  // Hold registers keep the last delivered word between returns
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_fetch_rdata <= '0;
      r_ld_rdata    <= '0;
    end else begin
      if (w_fetch_rvalid) r_fetch_rdata <= i_mem_rdata;
      if (w_ld_rvalid)    r_ld_rdata    <= i_mem_rdata;
    end
  end

  // Loader write counter: cleared on entry to LOAD, counts only in LOAD
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_count <= '0;
    end else if (r_state == StRun && i_ld_lock) begin
      r_wr_count <= '0;
    end else if (r_state == StLoad && w_ld_gnt && i_ld_we) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign o_fetch_gnt    = w_fetch_gnt;
  assign o_fetch_stall  = i_fetch_req & ~w_fetch_gnt;
  assign o_fetch_rvalid = w_fetch_rvalid;
  assign o_fetch_rdata  = w_fetch_rvalid ? i_mem_rdata : r_fetch_rdata;
  assign o_ld_gnt       = w_ld_gnt;
  assign o_ld_rvalid    = w_ld_rvalid;
  assign o_ld_rdata     = w_ld_rvalid ? i_mem_rdata : r_ld_rdata;
  assign o_ld_locked    = (r_state == StLoad);
  assign o_ld_wr_count  = r_wr_count;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: bench-side memory plus a behavioural model of the
// arbitration rules, compared on every cycle, with directed scenarios pinned
// by literal expectations followed by a randomized run.
module tb_imem_arbiter;
  localparam int AW  = 14;
  localparam int SMX = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          ld_lock = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_wdata = '0;
  logic [31:0]   mem_rdata = '0;

  logic          fetch_gnt, fetch_stall, fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          ld_gnt, ld_rvalid, ld_locked;
  logic [31:0]   ld_rdata;
  logic [15:0]   ld_wr_count;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  imem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMX)) dut (
    .i_clk(clk), .i_clr(clr),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_gnt(fetch_gnt), .o_fetch_stall(fetch_stall),
    .o_fetch_rvalid(fetch_rvalid), .o_fetch_rdata(fetch_rdata),
    .i_ld_lock(ld_lock), .i_ld_req(ld_req), .i_ld_we(ld_we),
    .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_ld_gnt(ld_gnt), .o_ld_rvalid(ld_rvalid), .o_ld_rdata(ld_rdata),
    .o_ld_locked(ld_locked), .o_ld_wr_count(ld_wr_count),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model state
  bit          m_valid = 0;
  bit          m_locked;
  int          m_starve;
  int          m_wr;
  int          pend_who = 0;  // 0 none, 1 fetch, 2 loader
  logic [31:0] pend_data = '0;
  logic [31:0] m_fhold, m_lhold;
  logic [31:0] m_mem [0:(1<<AW)-1];
  // Expected outputs for the current cycle
  bit          e_fgnt, e_lgnt, e_stall, e_frv, e_lrv, e_men, e_mwe;
  logic [31:0] e_frdata, e_lrdata, e_maddr, e_mwdata;

  // Advance the model across a clock edge using the inputs of the cycle just ended
  task automatic commit();
    if (clr) begin
      m_valid = 1; m_locked = 0; m_starve = 0; m_wr = 0;
      pend_who = 0; m_fhold = '0; m_lhold = '0;
    end else if (m_valid) begin
      if (e_frv) m_fhold = mem_rdata;
      if (e_lrv) m_lhold = mem_rdata;
      if (m_locked && e_lgnt && ld_we) m_wr = (m_wr + 1) % 65536;
      if (!m_locked && ld_lock) m_wr = 0;
      if (m_locked || !fetch_req || e_fgnt) m_starve = 0;
      else if (m_starve < SMX) m_starve++;
      m_locked = ld_lock;
      pend_who = 0;
      if (e_fgnt) begin
        pend_who = 1; pend_data = m_mem[fetch_addr];
      end else if (e_lgnt) begin
        if (ld_we) m_mem[ld_addr] = ld_wdata;
        else begin pend_who = 2; pend_data = m_mem[ld_addr]; end
      end
    end
  endtask

  // Compute this cycle's expected outputs and drive the memory read data
  task automatic eval();
    e_frv = (pend_who == 1) && !clr;
    e_lrv = (pend_who == 2) && !clr;
    mem_rdata = (pend_who != 0) ? pend_data : $urandom();
    e_frdata = e_frv ? mem_rdata : m_fhold;
    e_lrdata = e_lrv ? mem_rdata : m_lhold;
    e_fgnt = 0; e_lgnt = 0;
    if (!clr) begin
      if (m_locked) e_lgnt = ld_req;
      else if (fetch_req && ld_req) begin
        e_fgnt = (m_starve == SMX); e_lgnt = !e_fgnt;
      end else begin
        e_fgnt = fetch_req; e_lgnt = ld_req;
      end
    end
    e_stall  = fetch_req && !e_fgnt;
    e_men    = e_fgnt || e_lgnt;
    e_mwe    = e_lgnt && ld_we;
    e_maddr  = e_fgnt ? 32'(fetch_addr) : (e_lgnt ? 32'(ld_addr) : 32'd0);
    e_mwdata = e_lgnt ? ld_wdata : 32'd0;
  endtask

  task automatic step(input bit c, input bit fr, input int fa, input bit lk,
                      input bit lr, input bit lw, input int la, input logic [31:0] wd);
    @(posedge clk);
    #1;
    commit();
    clr = c; fetch_req = fr; fetch_addr = AW'(fa); ld_lock = lk;
    ld_req = lr; ld_we = lw; ld_addr = AW'(la); ld_wdata = wd;
    eval();
    #1;
  endtask

  task automatic idle(input bit lk);
    step(0, 0, 0, lk, 0, 0, 0, 32'd0);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("fetch_gnt", 32'(fetch_gnt), 32'(e_fgnt));
      chk("fetch_stall", 32'(fetch_stall), 32'(e_stall));
      chk("fetch_rvalid", 32'(fetch_rvalid), 32'(e_frv));
      chk("fetch_rdata", fetch_rdata, e_frdata);
      chk("ld_gnt", 32'(ld_gnt), 32'(e_lgnt));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(e_lrv));
      chk("ld_rdata", ld_rdata, e_lrdata);
      chk("ld_locked", 32'(ld_locked), 32'(m_locked));
      chk("ld_wr_count", 32'(ld_wr_count), 32'(m_wr));
      chk("mem_en", 32'(mem_en), 32'(e_men));
      chk("mem_we", 32'(mem_we), 32'(e_mwe));
      chk("mem_addr", 32'(mem_addr), e_maddr);
      chk("mem_wdata", mem_wdata, e_mwdata);
    end
  end

  initial begin
    logic [31:0] pat;
    bit lk_r;
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = 32'hA500_0000 | 32'(i);

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 32'd0);
    step(1, 1, 0, 0, 1, 0, 0, 32'd0);
    chk("lit_rst_mem_en", 32'(mem_en), 32'd0);
    chk("lit_rst_stall", 32'(fetch_stall), 32'd1);
    chk("lit_rst_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("lit_rst_rdata", fetch_rdata, 32'd0);
    chk("lit_rst_locked", 32'(ld_locked), 32'd0);
    chk("lit_rst_wrcnt", 32'(ld_wr_count), 32'd0);

    // Fetch-only reads at 0,1,2
    step(0, 1, 0, 0, 0, 0, 0, 32'd0);
    chk("lit_f0_gnt", 32'(fetch_gnt), 32'd1);
    chk("lit_f0_stall", 32'(fetch_stall), 32'd0);
    step(0, 1, 1, 0, 0, 0, 0, 32'd0);
    chk("lit_f0_rv", 32'(fetch_rvalid), 32'd1);
    chk("lit_f0_data", fetch_rdata, 32'hA500_0000);
    step(0, 1, 2, 0, 0, 0, 0, 32'd0);
    chk("lit_f1_data", fetch_rdata, 32'hA500_0001);
    idle(0);
    chk("lit_f2_data", fetch_rdata, 32'hA500_0002);

    // Loader write in RUN: no rvalid, counter untouched
    step(0, 0, 0, 0, 1, 1, 9, 32'h1234_5678);
    chk("lit_runwr_we", 32'(mem_we), 32'd1);
    idle(0);
    chk("lit_runwr_rv", 32'(ld_rvalid), 32'd0);
    chk("lit_runwr_cnt", 32'(ld_wr_count), 32'd0);

    // Owner change: fetch read then loader read
    step(0, 1, 2, 0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 1, 0, 7, 32'd0);
    chk("lit_oc_frv", 32'(fetch_rvalid), 32'd1);
    chk("lit_oc_lrv0", 32'(ld_rvalid), 32'd0);
    chk("lit_oc_fdata", fetch_rdata, 32'hA500_0002);
    idle(0);
    chk("lit_oc_lrv", 32'(ld_rvalid), 32'd1);
    chk("lit_oc_frv0", 32'(fetch_rvalid), 32'd0);
    chk("lit_oc_ldata", ld_rdata, 32'hA500_0007);

    // Both requesting: L,L,L,L,F repeating
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 20 + i, 0, 1, 0, 40 + i, 32'd0);
      pat[i] = fetch_gnt;
    end
    chk("lit_starve_pattern", pat, 32'h0000_0210);
    idle(0);

    // Load-lock: fetch granted in transition cycle, then blocked
    step(0, 1, 3, 1, 0, 0, 0, 32'd0);
    chk("lit_lk_fgnt", 32'(fetch_gnt), 32'd1);
    step(0, 1, 3, 1, 1, 1, 5, 32'hDEAD_BEEF);
    chk("lit_lk_locked", 32'(ld_locked), 32'd1);
    chk("lit_lk_fgnt0", 32'(fetch_gnt), 32'd0);
    chk("lit_lk_frv", 32'(fetch_rvalid), 32'd1);
    step(0, 1, 3, 1, 1, 1, 6, 32'h0000_0001);
    step(0, 1, 3, 1, 1, 1, 7, 32'h0000_0002);
    idle(1);
    chk("lit_lk_cnt", 32'(ld_wr_count), 32'd3);
    idle(0);
    step(0, 1, 5, 0, 0, 0, 0, 32'd0);
    chk("lit_unlk_gnt", 32'(fetch_gnt), 32'd1);
    step(0, 1, 6, 0, 0, 0, 0, 32'd0);
    chk("lit_rd5", fetch_rdata, 32'hDEAD_BEEF);
    step(0, 1, 7, 0, 0, 0, 0, 32'd0);
    chk("lit_rd6", fetch_rdata, 32'h0000_0001);
    idle(0);
    chk("lit_rd7", fetch_rdata, 32'h0000_0002);
    chk("lit_cnt_hold", 32'(ld_wr_count), 32'd3);

    // Reset right after a fetch grant
    step(0, 1, 4, 0, 0, 0, 0, 32'd0);
    step(1, 1, 4, 0, 0, 0, 0, 32'd0);
    chk("lit_mr_rv", 32'(fetch_rvalid), 32'd0);
    chk("lit_mr_en", 32'(mem_en), 32'd0);
    idle(0);
    chk("lit_mr_rv2", 32'(fetch_rvalid), 32'd0);
    chk("lit_mr_rdata", fetch_rdata, 32'd0);
    chk("lit_mr_cnt", 32'(ld_wr_count), 32'd0);

    // Randomized traffic
    lk_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) lk_r = ~lk_r;
      step(($urandom_range(96) == 0), ($urandom_range(3) != 0), $urandom_range(31), lk_r,
           ($urandom_range(3) != 0), ($urandom_range(2) == 0), $urandom_range(31), $urandom());
    end
    idle(0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port program-memory arbiter between the instruction-fetch stage and the program loader/debug port. It owns the one port of the synchronous program ROM/RAM: 14-bit word address, one-cycle read latency. Each cycle it grants the port to at most one requester, routes returned read data to that requester, and raises a fetch stall when fetch loses. It also enforces a load-lock mode that halts fetch while a program image is downloaded.

## Interface
- ADDR_W, 14, word-address width (pc[15:2])
- STARVE_MAX, 4, consecutive lost fetch cycles before fetch is forced through (1..15)

- clk  in  1  system clock, rising edge
- clr  in  1  synchronous reset, active-high
- fetch_req  in  1  fetch wants an instruction word this cycle
- fetch_addr  in  ADDR_W  fetch word address
- fetch_gnt  out  1  fetch owns the port this cycle
- fetch_stall  out  1  fetch_req & ~fetch_gnt; holds the pc and IF/ID registers
- fetch_rvalid  out  1  fetch_rdata valid; one cycle after fetch_gnt
- fetch_rdata  out  32  instruction word
- ld_lock  in  1  loader requests exclusive mode (CPU halted)
- ld_req  in  1  loader access request
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader owns the port this cycle
- ld_rvalid  out  1  ld_rdata valid; one cycle after a granted loader read
- ld_rdata  out  32  loader read data
- ld_locked  out  1  arbiter is in LOAD state
- ld_wr_count  out  16  writes completed since entering LOAD
- mem_en, mem_we  out  1 each  memory port enable, write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en & ~mem_we

## Operation
- FSM states: RUN and LOAD.
  - RUN→LOAD when ld_lock=1. LOAD→RUN when ld_lock=0.
  - Transitions take effect at the clock edge; grants in the transition cycle follow the current state.
- Grant rules in RUN:
  - Only one requester: it is granted.
  - Both requesting: the loader wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Grant rules in LOAD:
  - fetch_gnt is always 0.
  - The loader is granted whenever ld_req=1.
- starve_cnt:
  - Increments when fetch_req=1 and fetch_gnt=0 in RUN.
  - Cleared when fetch is granted, when fetch_req=0, or in LOAD.
  - Saturates at STARVE_MAX.
- Memory port:
  - mem_en = fetch_gnt | ld_gnt.
  - mem_we = ld_gnt & ld_we. A fetch never writes.
  - mem_addr and mem_wdata are taken from the granted requester; both are 0 when idle.
- Read return:
  - A registered owner tag records which requester was granted a read.
  - Next cycle, mem_rdata goes to that requester's rdata and its rvalid pulses for 1 cycle.
  - Loader writes produce no rvalid.
- rdata outputs hold their last delivered value until the next rvalid.
- ld_wr_count:
  - Increments on each granted loader write while in LOAD; wraps 0xFFFF→0.
  - Cleared on the RUN→LOAD transition.
  - Holds its value in RUN.
- Grants and mem_* are combinational from the current requests and state. rvalid, rdata, state, counters and the tag are registered.

## Timing
- Reset (clr=1 at an edge):
  - state=RUN, starve_cnt=0, tag=none, ld_wr_count=0.
  - fetch_rvalid=0, ld_rvalid=0, fetch_rdata=0, ld_rdata=0, ld_locked=0.
- While clr=1:
  - All grants are forced 0 and mem_en=0.
  - fetch_stall = fetch_req.
- Reset mid-operation: a read granted in the cycle before clr rises produces no rvalid. The tag is cleared by reset.
- Read latency: exactly 1 cycle, grant cycle to rvalid cycle. Back-to-back grants give back-to-back rvalids.
- Simultaneous owner change: a fetch read in cycle N followed by a loader read in cycle N+1:
  - Cycle N+1: fetch_rvalid=1.
  - Cycle N+2: ld_rvalid=1.
  - Never both rvalids in the same cycle.
- ld_lock rising with fetch_req=1: fetch may still be granted in that cycle. From the next cycle fetch is blocked, and its read still returns.
- Fairness bound: with both requesting continuously in RUN, fetch is granted once every STARVE_MAX+1 cycles.

## Test plan
- Reset then RUN with only fetch_req=1 at addresses 0,1,2 → fetch_gnt=1 every cycle, fetch_stall=0, fetch_rvalid one cycle later with mem contents at 0,1,2.
- Both fetch_req and ld_req held high (loader reads), STARVE_MAX=4 → grant pattern L,L,L,L,F repeating; fetch_stall=1 on exactly the L cycles; rdata routed per owner.
- ld_lock=1, then 3 loader writes (addr 5/6/7, data 0xDEADBEEF/0x1/0x2) while fetch_req=1 → ld_locked=1, fetch_gnt=0, ld_wr_count=3; after ld_lock=0, fetch reads of 5..7 return the written words.
- Loader write with ld_req=1, ld_we=1 in RUN → mem_we=1, no ld_rvalid, ld_wr_count unchanged (0).
- Fetch read granted, clr=1 on the next edge → no fetch_rvalid, all outputs at reset values, mem_en=0 while clr=1.
- Fetch grant in cycle N, loader read in cycle N+1 → fetch_rvalid in N+1 only, ld_rvalid in N+2 only, with the correct data in each.
